// File: rtl/sfp_rx_deframer.sv
// -----------------------------------------------------------------------------
// sfp_rx_deframer
//   Receives framed words from the SFP link and publishes the payload of each
//   good frame to the PS side. Frame layout on the link:
//     header   : {SOF_MARK[15:0], seq[7:0], len[7:0]}   (len must equal WORDS)
//     payload  : WORDS x 32-bit words
//     checksum : XOR of all payload words, the only word carrying tlast
//   Payload is assembled in a shadow buffer and copied to o_sfp_rx_data only
//   after the checksum matches, so a partial or corrupt frame is never visible.
//
//   Handshake: i_rx_tvalid qualifies i_rx_tdata/i_rx_tlast on each rising edge
//   of i_clk; there is no ready, so every valid word is consumed on that edge.
//
// Ports
//   i_clk              rising-edge clock
//   i_rst              synchronous active-high reset (wins over enable)
//   i_zynq_sfp_en      deframer enable; low forces IDLE and drops any frame
//   i_rx_tdata         link receive word
//   i_rx_tvalid        word valid
//   i_rx_tlast         last word of a link frame
//   o_sfp_rx_data      last good payload, word k at [32k+31:32k]
//   o_sfp_rx_end_flag  one-cycle pulse, the cycle after a good checksum word
//   o_rx_seq           sequence number of the last good frame
//   o_frame_ok_cnt     good frames (saturating)
//   o_frame_err_cnt    rejected frames (saturating)
//   o_seq_err_cnt      sequence gaps between good frames (saturating)
//   o_state            current FSM state (IDLE=0 HDR=1 PAY=2 CHK=3 DROP=4)
// -----------------------------------------------------------------------------
module sfp_rx_deframer #(
  parameter int          WORDS    = 38,
  parameter logic [15:0] SOF_MARK = 16'hA55A
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_zynq_sfp_en,
  input  logic [31:0]           i_rx_tdata,
  input  logic                  i_rx_tvalid,
  input  logic                  i_rx_tlast,
  output logic [WORDS*32-1:0]   o_sfp_rx_data,
  output logic                  o_sfp_rx_end_flag,
  output logic [7:0]            o_rx_seq,
  output logic [15:0]           o_frame_ok_cnt,
  output logic [15:0]           o_frame_err_cnt,
  output logic [15:0]           o_seq_err_cnt,
  output logic [2:0]            o_state
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_CHK  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t              state;
  logic [WORDS*32-1:0] shadow;
  logic [IW-1:0]       idx;
  logic [31:0]         acc;
  logic [7:0]          seq_cap;
  // Set until the first good frame after reset or after a stay in IDLE;
  // there is no previous sequence number to compare against then.
  logic                first;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= S_IDLE;
      shadow            <= '0;
      idx               <= '0;
      acc               <= '0;
      seq_cap           <= '0;
      first             <= 1'b1;
      o_sfp_rx_data     <= '0;
      o_sfp_rx_end_flag <= 1'b0;
      o_rx_seq          <= '0;
      o_frame_ok_cnt    <= '0;
      o_frame_err_cnt   <= '0;
      o_seq_err_cnt     <= '0;
    end else begin
      o_sfp_rx_end_flag <= 1'b0;
      if (!i_zynq_sfp_en) begin
        // Disable discards any partial frame silently.
        state <= S_IDLE;
        first <= 1'b1;
      end else begin
        case (state)
          S_IDLE: state <= S_HDR;

          S_HDR: if (i_rx_tvalid) begin
            if (i_rx_tdata[31:16] == SOF_MARK && i_rx_tdata[7:0] == 8'(WORDS)
                && !i_rx_tlast) begin
              seq_cap <= i_rx_tdata[15:8];
              idx     <= '0;
              acc     <= '0;
              state   <= S_PAY;
            end else begin
              o_frame_err_cnt <= sat_inc(o_frame_err_cnt);
              // A bad word that already ends the link frame leaves nothing to skip.
              state <= i_rx_tlast ? S_HDR : S_DROP;
            end
          end

          S_PAY: if (i_rx_tvalid) begin
            shadow[idx*32 +: 32] <= i_rx_tdata;
            acc                  <= acc ^ i_rx_tdata;
            if (i_rx_tlast) begin
              o_frame_err_cnt <= sat_inc(o_frame_err_cnt);
              state           <= S_HDR;
            end else if (idx == IW'(WORDS - 1)) begin
              state <= S_CHK;
            end else begin
              idx <= idx + IW'(1);
            end
          end

          S_CHK: if (i_rx_tvalid) begin
            if (i_rx_tlast && i_rx_tdata == acc) begin
              o_sfp_rx_data     <= shadow;
              o_sfp_rx_end_flag <= 1'b1;
              o_rx_seq          <= seq_cap;
              o_frame_ok_cnt    <= sat_inc(o_frame_ok_cnt);
              if (!first && seq_cap != o_rx_seq + 8'd1)
                o_seq_err_cnt <= sat_inc(o_seq_err_cnt);
              first <= 1'b0;
              state <= S_HDR;
            end else begin
              o_frame_err_cnt <= sat_inc(o_frame_err_cnt);
              state           <= i_rx_tlast ? S_HDR : S_DROP;
            end
          end

          S_DROP: if (i_rx_tvalid && i_rx_tlast) state <= S_HDR;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_sfp_rx_deframer.sv
module tb_sfp_rx_deframer;

  localparam int WORDS = 38;
  localparam int DW    = WORDS * 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst;
  logic            i_zynq_sfp_en;
  logic [31:0]     i_rx_tdata;
  logic            i_rx_tvalid;
  logic            i_rx_tlast;
  logic [DW-1:0]   o_sfp_rx_data;
  logic            o_sfp_rx_end_flag;
  logic [7:0]      o_rx_seq;
  logic [15:0]     o_frame_ok_cnt;
  logic [15:0]     o_frame_err_cnt;
  logic [15:0]     o_seq_err_cnt;
  logic [2:0]      o_state;

  sfp_rx_deframer #(.WORDS(WORDS), .SOF_MARK(16'hA55A)) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_zynq_sfp_en     (i_zynq_sfp_en),
    .i_rx_tdata        (i_rx_tdata),
    .i_rx_tvalid       (i_rx_tvalid),
    .i_rx_tlast        (i_rx_tlast),
    .o_sfp_rx_data     (o_sfp_rx_data),
    .o_sfp_rx_end_flag (o_sfp_rx_end_flag),
    .o_rx_seq          (o_rx_seq),
    .o_frame_ok_cnt    (o_frame_ok_cnt),
    .o_frame_err_cnt   (o_frame_err_cnt),
    .o_seq_err_cnt     (o_seq_err_cnt),
    .o_state           (o_state)
  );

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  logic prev_flag = 1'b0;

  logic [DW-1:0] frame_data;  // payload of the frame most recently sent
  logic [DW-1:0] exp_data;    // expected o_sfp_rx_data

  // scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag);
    checks++;
    assert (o_sfp_rx_data === exp_data) else begin
      failures++;
      $error("FAIL %s observed_w0=0x%0h expected_w0=0x%0h observed_w37=0x%0h expected_w37=0x%0h",
             tag, o_sfp_rx_data[31:0], exp_data[31:0],
             o_sfp_rx_data[DW-1 -: 32], exp_data[DW-1 -: 32]);
    end
  endtask

  // pulse monitor: counts end_flag pulses and rejects back-to-back pulses
  always @(negedge clk) begin
    if (o_sfp_rx_end_flag === 1'b1) begin
      pulse_cnt++;
      checks++;
      assert (prev_flag === 1'b0) else begin
        failures++;
        $error("FAIL end_flag_consecutive observed=1 expected=0");
      end
    end
    prev_flag = o_sfp_rx_end_flag;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit gap);
    i_rx_tdata  = d;
    i_rx_tlast  = last;
    i_rx_tvalid = 1'b1;
    tick();
    i_rx_tvalid = 1'b0;
    i_rx_tlast  = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_header(input logic [7:0] seq, input bit gap);
    send_word({16'hA55A, seq, 8'd38}, 1'b0, gap);
  endtask

  // header + payload (base+1 .. base+38) + checksum; no gap after checksum so
  // the caller samples the cycle right after the checksum edge
  task automatic send_frame(input logic [7:0] seq, input logic [31:0] base,
                            input bit bad_csum, input bit gap);
    logic [31:0] w;
    logic [31:0] cs;
    cs = 32'h0;
    send_header(seq, gap);
    for (int k = 0; k < WORDS; k++) begin
      w = base + 32'(k) + 32'd1;
      cs = cs ^ w;
      frame_data[k*32 +: 32] = w;
      send_word(w, 1'b0, gap);
    end
    send_word(bad_csum ? 32'h0 : cs, 1'b1, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_zynq_sfp_en = 1'b0;
    i_rx_tdata = '0; i_rx_tvalid = 1'b0; i_rx_tlast = 1'b0;
    exp_data = '0; frame_data = '0;

    // reset state
    tick(); tick();
    chk("rst_state", 32'(o_state), 32'd0);
    chk_data("rst_data");
    chk("rst_flag", 32'(o_sfp_rx_end_flag), 32'd0);
    chk("rst_seq", 32'(o_rx_seq), 32'd0);
    chk("rst_ok", 32'(o_frame_ok_cnt), 32'd0);
    chk("rst_err", 32'(o_frame_err_cnt), 32'd0);
    chk("rst_seqerr", 32'(o_seq_err_cnt), 32'd0);

    i_rst = 1'b0; i_zynq_sfp_en = 1'b1;
    tick();
    chk("en_to_hdr", 32'(o_state), 32'd1);

    // good frame, seq 1, payload 1..38, checksum 0x27
    send_frame(8'd1, 32'd0, 1'b0, 1'b0);
    exp_data = frame_data;
    chk("g1_flag", 32'(o_sfp_rx_end_flag), 32'd1);
    chk("g1_w0", o_sfp_rx_data[31:0], 32'd1);
    chk("g1_w37", o_sfp_rx_data[DW-1 -: 32], 32'd38);
    chk_data("g1_data");
    chk("g1_seq", 32'(o_rx_seq), 32'd1);
    chk("g1_ok", 32'(o_frame_ok_cnt), 32'd1);
    chk("g1_state", 32'(o_state), 32'd1);
    tick();
    chk("g1_flag_drop", 32'(o_sfp_rx_end_flag), 32'd0);
    chk("g1_pulses", 32'(pulse_cnt), 32'd1);

    // bad checksum: rejected, data keeps frame 1
    send_frame(8'd2, 32'd500, 1'b1, 1'b0);
    chk("bc_flag", 32'(o_sfp_rx_end_flag), 32'd0);
    chk("bc_err", 32'(o_frame_err_cnt), 32'd1);
    chk("bc_state", 32'(o_state), 32'd1);
    chk_data("bc_data");
    chk("bc_ok", 32'(o_frame_ok_cnt), 32'd1);
    send_frame(8'd2, 32'd100, 1'b0, 1'b0);
    exp_data = frame_data;
    chk("g2_flag", 32'(o_sfp_rx_end_flag), 32'd1);
    chk_data("g2_data");
    chk("g2_ok", 32'(o_frame_ok_cnt), 32'd2);
    chk("g2_seqerr", 32'(o_seq_err_cnt), 32'd0);

    // early tlast on payload word 10
    send_header(8'd3, 1'b0);
    for (int k = 1; k < 10; k++) send_word(32'(k), 1'b0, 1'b0);
    send_word(32'd10, 1'b1, 1'b0);
    chk("et_err", 32'(o_frame_err_cnt), 32'd2);
    chk("et_state", 32'(o_state), 32'd1);
    chk("et_flag", 32'(o_sfp_rx_end_flag), 32'd0);
    chk_data("et_data");
    send_frame(8'd3, 32'd200, 1'b0, 1'b0);
    exp_data = frame_data;
    chk("g3_flag", 32'(o_sfp_rx_end_flag), 32'd1);
    chk("g3_ok", 32'(o_frame_ok_cnt), 32'd3);
    chk("g3_seq", 32'(o_rx_seq), 32'd3);

    // sequence gap 3 -> 5
    send_frame(8'd5, 32'd300, 1'b0, 1'b0);
    exp_data = frame_data;
    chk("g5_seqerr", 32'(o_seq_err_cnt), 32'd1);
    chk("g5_ok", 32'(o_frame_ok_cnt), 32'd4);

    // leaving IDLE skips the sequence check
    i_zynq_sfp_en = 1'b0;
    tick();
    chk("dis_state", 32'(o_state), 32'd0);
    i_zynq_sfp_en = 1'b1;
    tick();
    chk("reen_state", 32'(o_state), 32'd1);
    send_frame(8'd9, 32'd400, 1'b0, 1'b0);
    exp_data = frame_data;
    chk("g9_flag", 32'(o_sfp_rx_end_flag), 32'd1);
    chk("g9_seqerr", 32'(o_seq_err_cnt), 32'd1);
    chk("g9_seq", 32'(o_rx_seq), 32'd9);
    chk("g9_ok", 32'(o_frame_ok_cnt), 32'd5);

    // bad SOF without tlast -> DROP until tlast
    send_word(32'h1234_0026, 1'b0, 1'b0);
    chk("sof_err", 32'(o_frame_err_cnt), 32'd3);
    chk("sof_drop", 32'(o_state), 32'd4);
    send_word(32'h0000_0001, 1'b0, 1'b0);
    send_word(32'h0000_0002, 1'b0, 1'b0);
    chk("sof_still_drop", 32'(o_state), 32'd4);
    send_word(32'h0000_0003, 1'b1, 1'b0);
    chk("sof_hdr", 32'(o_state), 32'd1);
    chk("sof_pulses", 32'(pulse_cnt), 32'd5);
    chk_data("sof_data");

    // tvalid toggling through a good frame, payload 1..38
    send_frame(8'd10, 32'd0, 1'b0, 1'b1);
    exp_data = frame_data;
    chk("gap_flag", 32'(o_sfp_rx_end_flag), 32'd1);
    chk("gap_w0", o_sfp_rx_data[31:0], 32'd1);
    chk("gap_w37", o_sfp_rx_data[DW-1 -: 32], 32'd38);
    chk_data("gap_data");
    chk("gap_ok", 32'(o_frame_ok_cnt), 32'd6);
    chk("gap_seqerr", 32'(o_seq_err_cnt), 32'd1);
    tick();
    chk("gap_flag_drop", 32'(o_sfp_rx_end_flag), 32'd0);

    // enable drop mid-payload
    send_header(8'd11, 1'b0);
    for (int k = 0; k < 10; k++) send_word(32'hDEAD_0000 + 32'(k), 1'b0, 1'b0);
    i_zynq_sfp_en = 1'b0;
    tick();
    chk("mden_state", 32'(o_state), 32'd0);
    chk("mden_ok", 32'(o_frame_ok_cnt), 32'd6);
    chk("mden_err", 32'(o_frame_err_cnt), 32'd3);
    chk("mden_flag", 32'(o_sfp_rx_end_flag), 32'd0);
    chk_data("mden_data");
    i_zynq_sfp_en = 1'b1;
    tick();
    chk("mden_reen", 32'(o_state), 32'd1);

    // reset mid-payload with enable held high
    send_header(8'd12, 1'b0);
    for (int k = 0; k < 5; k++) send_word(32'hBEEF_0000 + 32'(k), 1'b0, 1'b0);
    i_rst = 1'b1;
    tick();
    exp_data = '0;
    chk("mrst_state", 32'(o_state), 32'd0);
    chk("mrst_flag", 32'(o_sfp_rx_end_flag), 32'd0);
    chk("mrst_ok", 32'(o_frame_ok_cnt), 32'd0);
    chk("mrst_err", 32'(o_frame_err_cnt), 32'd0);
    chk_data("mrst_data");
    i_rst = 1'b0;
    tick();
    chk("mrst_hdr", 32'(o_state), 32'd1);

    // first frame after reset: no sequence check against seq 10
    send_frame(8'd77, 32'd600, 1'b0, 1'b0);
    exp_data = frame_data;
    chk("g77_flag", 32'(o_sfp_rx_end_flag), 32'd1);
    chk("g77_seq", 32'(o_rx_seq), 32'd77);
    chk("g77_ok", 32'(o_frame_ok_cnt), 32'd1);
    chk("g77_seqerr", 32'(o_seq_err_cnt), 32'd0);
    chk_data("g77_data");
    tick();
    chk("total_pulses", 32'(pulse_cnt), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
